// File: rtl/mlaccel_memory_loader.sv
// Host load/store engine: packs host write words into 4-word memory chunks
// and unpacks read chunks to the host, via a req/grant shared memory port.
module mlaccel_memory_loader #(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [15:0] rd_data,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wen,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WORDS = 4;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 3;
  localparam int unsigned LAT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WFILL = 3'd1,
    S_WRITE = 3'd2,
    S_RADDR = 3'd3,
    S_RWAIT = 3'd4,
    S_RSEND = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [AW-1:0]            rem_q, rem_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [1:0]               idx_q, idx_d;
  logic [CW-1:0]            n_q, n_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic [WORDS-1:0][DW-1:0] data_q, data_d;
  logic                     done_q, done_d;

  logic [CW-1:0]            cnt_inc;
  logic [AW-1:0]            rem_after_wr;
  logic [AW-1:0]            rem_after_rd;

  // State register; reset aborts any command in flight
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: address, remaining count, chunk buffer, counters
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      n_q    <= '0;
      lat_q  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      n_q    <= n_d;
      lat_q  <= lat_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    n_d          = n_q;
    lat_d        = lat_q;
    data_d       = data_q;
    done_d       = 1'b0;
    cnt_inc      = cnt_q + CW'(1);
    rem_after_wr = rem_q - AW'(cnt_q);
    rem_after_rd = rem_q - AW'(n_q);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          cnt_d  = '0;
          idx_d  = '0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else if (cmd_write) begin
            state_d = S_WFILL;
          end else begin
            state_d = S_RADDR;
          end
        end
      end
      S_WFILL: begin
        if (wr_valid) begin
          data_d[cnt_q[1:0]] = wr_data;
          cnt_d              = cnt_inc;
          // rem_q is nonzero here, so the chunk closes at 4 or at the tail
          if (cnt_inc == CW'(WORDS) || AW'(cnt_inc) == rem_q) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (mem_grant) begin
          addr_d = addr_q + AW'(cnt_q);
          rem_d  = rem_after_wr;
          cnt_d  = '0;
          if (rem_after_wr != '0) begin
            state_d = S_WFILL;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_RADDR: begin
        if (mem_grant) begin
          lat_d   = '0;
          state_d = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
          data_d  = mem_rdata;
          n_d     = (rem_q >= AW'(WORDS)) ? CW'(WORDS) : rem_q[CW-1:0];
          idx_d   = '0;
          state_d = S_RSEND;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_RSEND: begin
        if (rd_ready) begin
          if ({1'b0, idx_q} == n_q - CW'(1)) begin
            addr_d = addr_q + AW'(n_q);
            rem_d  = rem_after_rd;
            idx_d  = '0;
            if (rem_after_rd != '0) begin
              state_d = S_RADDR;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the state register and datapath flops
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    mem_req   = 1'b0;
    mem_wen   = '0;
    mem_wdata = '0;
    mem_addr  = addr_q;
    rd_data   = data_q[idx_q];
    done      = done_q;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_WFILL: begin
        wr_ready = 1'b1;
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_wdata = data_q;
        for (int unsigned k = 0; k < WORDS; k++) begin
          if (CW'(k) < cnt_q) begin
            mem_wen[2*k +: 2] = 2'b11;
          end
        end
      end
      S_RADDR: begin
        mem_req = 1'b1;
      end
      S_RSEND: begin
        rd_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mlaccel_memory_loader.sv
// Directed bench for mlaccel_memory_loader with a 2-cycle-latency memory model.
module tb_mlaccel_memory_loader;

  logic        clock;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        mem_req;
  logic        mem_grant;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wen;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        busy;
  logic        done;

  mlaccel_memory_loader #(.READ_LATENCY(2)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .mem_req   (mem_req),
    .mem_grant (mem_grant),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model and port monitor
  logic [15:0] mem [0:65535];
  logic [15:0] rd_a1, rd_a2;
  logic [15:0] wlog_addr [$];
  logic [7:0]  wlog_wen  [$];
  logic [63:0] wlog_data [$];
  logic [15:0] rlog_addr [$];
  int          req_seen;
  int          wen_any;
  int          done_total;

  initial begin
    req_seen   = 0;
    wen_any    = 0;
    done_total = 0;
  end

  assign mem_rdata = {mem[rd_a2 + 16'd3], mem[rd_a2 + 16'd2],
                      mem[rd_a2 + 16'd1], mem[rd_a2]};

  always @(posedge clock) begin
    if (mem_req) req_seen++;
    if (mem_wen != 8'h00) wen_any++;
    if (done) done_total++;
    rd_a2 <= rd_a1;
    if (mem_req && mem_grant) begin
      if (mem_wen != 8'h00) begin
        for (int k = 0; k < 4; k++) begin
          if (mem_wen[2*k]) mem[mem_addr + 16'(k)] <= mem_wdata[16*k +: 16];
        end
        wlog_addr.push_back(mem_addr);
        wlog_wen.push_back(mem_wen);
        wlog_data.push_back(mem_wdata);
      end else begin
        rd_a1 <= mem_addr;
        rlog_addr.push_back(mem_addr);
      end
    end
  end

  int          n_checks;
  int          n_fail;
  logic [15:0] wsrc [16];
  logic [15:0] rd_got [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and service streams/grant until two cycles after done
  task automatic run_cmd(input logic wr, input logic [15:0] addr, input logic [15:0] len,
                         input int stall_n, input logic toggle,
                         output int done_cyc, output int done_cnt);
    int          cyc;
    int          wr_idx;
    int          stall;
    logic        prev_stall;
    logic        prev_rdhold;
    logic [15:0] p_addr;
    logic [7:0]  p_wen;
    logic [63:0] p_wdata;
    logic [15:0] p_rd;
    logic        fin;
    rd_got.delete();
    wr_idx = 0; stall = 0; prev_stall = 1'b0; prev_rdhold = 1'b0;
    p_addr = '0; p_wen = '0; p_wdata = '0; p_rd = '0;
    cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    if (len != 16'd0) chk("busy_after_cmd", 64'(busy), 64'd1);
    cyc = 0; done_cyc = -1; done_cnt = 0; fin = 1'b0;
    while (!fin) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
        fin = 1'b1;
      end else if (cyc >= 400) begin
        chk("done_before_timeout", 64'(done_cnt), 64'd1);
        fin = 1'b1;
      end else begin
        wr_valid  = wr && (wr_idx < int'(len)) && (!toggle || cyc[0]);
        wr_data   = (wr_idx < 16) ? wsrc[wr_idx] : 16'h0;
        rd_ready  = !toggle || cyc[0];
        mem_grant = mem_req && (stall >= stall_n);
        if (prev_stall) begin
          chk("stall_req",   64'(mem_req),   64'd1);
          chk("stall_addr",  64'(mem_addr),  64'(p_addr));
          chk("stall_wen",   64'(mem_wen),   64'(p_wen));
          chk("stall_wdata", mem_wdata,      p_wdata);
        end
        if (prev_rdhold) begin
          chk("hold_rd_valid", 64'(rd_valid), 64'd1);
          chk("hold_rd_data",  64'(rd_data),  64'(p_rd));
        end
        if (wr_valid && wr_ready) wr_idx++;
        if (rd_valid && rd_ready) rd_got.push_back(rd_data);
        prev_stall  = mem_req && !mem_grant;
        p_addr = mem_addr; p_wen = mem_wen; p_wdata = mem_wdata;
        prev_rdhold = rd_valid && !rd_ready;
        p_rd   = rd_data;
        stall  = (mem_req && !mem_grant) ? stall + 1 : 0;
        @(posedge clock); #1;
        cyc++;
      end
    end
    wr_valid = 1'b0; rd_ready = 1'b0; mem_grant = 1'b0;
  endtask

  initial begin
    int dcyc;
    int dcnt;
    int wb;
    int rb;
    int rq;
    int wa;
    int dt;
    n_checks = 0; n_fail = 0;
    resetn = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; mem_grant = 1'b0;
    for (int i = 0; i < 16; i++) wsrc[i] = '0;

    // Reset values
    #2 resetn = 1'b0;
    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_mem_req",   64'(mem_req),   64'd0);
    chk("rst_mem_wen",   64'(mem_wen),   64'd0);
    chk("rst_mem_addr",  64'(mem_addr),  64'd0);
    chk("rst_mem_wdata", mem_wdata,      64'd0);
    chk("rst_rd_valid",  64'(rd_valid),  64'd0);
    chk("rst_rd_data",   64'(rd_data),   64'd0);
    chk("rst_wr_ready",  64'(wr_ready),  64'd0);
    chk("rst_done",      64'(done),      64'd0);
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    // Aligned 8-word write, grant always
    for (int i = 0; i < 8; i++) wsrc[i] = 16'(16'h1111 * (i + 1));
    wb = wlog_addr.size();
    run_cmd(1'b1, 16'h0010, 16'd8, 0, 1'b0, dcyc, dcnt);
    chk("w8_nwrites", 64'(wlog_addr.size() - wb), 64'd2);
    chk("w8_addr0",   64'(wlog_addr[wb]),      64'h0010);
    chk("w8_wen0",    64'(wlog_wen[wb]),       64'hFF);
    chk("w8_data0",   wlog_data[wb],           64'h4444_3333_2222_1111);
    chk("w8_addr1",   64'(wlog_addr[wb+1]),    64'h0014);
    chk("w8_wen1",    64'(wlog_wen[wb+1]),     64'hFF);
    chk("w8_data1",   wlog_data[wb+1],         64'h8888_7777_6666_5555);
    chk("w8_done_cnt", 64'(dcnt), 64'd1);
    chk("w8_done_cyc", 64'(dcyc), 64'd10);
    chk("w8_idle_busy", 64'(busy), 64'd0);

    // Unaligned 6-word write with partial tail, then readback
    for (int i = 0; i < 6; i++) wsrc[i] = 16'(16'hA001 + i);
    wb = wlog_addr.size();
    run_cmd(1'b1, 16'h0003, 16'd6, 0, 1'b0, dcyc, dcnt);
    chk("w6_nwrites", 64'(wlog_addr.size() - wb), 64'd2);
    chk("w6_addr0",   64'(wlog_addr[wb]),      64'h0003);
    chk("w6_wen0",    64'(wlog_wen[wb]),       64'hFF);
    chk("w6_data0",   wlog_data[wb],           64'hA004_A003_A002_A001);
    chk("w6_addr1",   64'(wlog_addr[wb+1]),    64'h0007);
    chk("w6_wen1",    64'(wlog_wen[wb+1]),     64'h0F);
    chk("w6_data1_lo", 64'(wlog_data[wb+1][31:0]), 64'hA006_A005);
    chk("w6_done_cyc", 64'(dcyc), 64'd8);
    rb = rlog_addr.size();
    run_cmd(1'b0, 16'h0003, 16'd6, 0, 1'b0, dcyc, dcnt);
    chk("r6_nreads", 64'(rlog_addr.size() - rb), 64'd2);
    chk("r6_raddr1", 64'(rlog_addr[rb+1]), 64'h0007);
    chk("r6_count",  64'(rd_got.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("r6_word%0d", i), 64'(rd_got[i]), 64'(16'hA001 + i));
    chk("r6_done_cnt", 64'(dcnt), 64'd1);
    chk("r6_done_cyc", 64'(dcyc), 64'd12);

    // Chunk straddling 0xFFFF -> 0x0000
    wsrc[0] = 16'hBEEF; wsrc[1] = 16'hCAFE; wsrc[2] = 16'h1234; wsrc[3] = 16'h5678;
    wb = wlog_addr.size();
    run_cmd(1'b1, 16'hFFFE, 16'd4, 0, 1'b0, dcyc, dcnt);
    chk("wrap_w_addr", 64'(wlog_addr[wb]), 64'hFFFE);
    chk("wrap_w_data", wlog_data[wb],      64'h5678_1234_CAFE_BEEF);
    rb = rlog_addr.size();
    run_cmd(1'b0, 16'hFFFE, 16'd4, 0, 1'b0, dcyc, dcnt);
    chk("wrap_nreads", 64'(rlog_addr.size() - rb), 64'd1);
    chk("wrap_raddr",  64'(rlog_addr[rb]), 64'hFFFE);
    chk("wrap_count",  64'(rd_got.size()), 64'd4);
    chk("wrap_rd0", 64'(rd_got[0]), 64'hBEEF);
    chk("wrap_rd1", 64'(rd_got[1]), 64'hCAFE);
    chk("wrap_rd2", 64'(rd_got[2]), 64'h1234);
    chk("wrap_rd3", 64'(rd_got[3]), 64'h5678);
    chk("wrap_done_cyc", 64'(dcyc), 64'd7);

    // Zero-length commands in both directions
    rq = req_seen;
    run_cmd(1'b1, 16'h0040, 16'd0, 0, 1'b0, dcyc, dcnt);
    chk("len0w_done_cyc", 64'(dcyc), 64'd0);
    chk("len0w_done_cnt", 64'(dcnt), 64'd1);
    chk("len0w_cmd_ready", 64'(cmd_ready), 64'd1);
    run_cmd(1'b0, 16'h0040, 16'd0, 0, 1'b0, dcyc, dcnt);
    chk("len0r_done_cyc", 64'(dcyc), 64'd0);
    chk("len0r_done_cnt", 64'(dcnt), 64'd1);
    chk("len0_no_req", 64'(req_seen - rq), 64'd0);

    // Backpressure: grant withheld 5 cycles, host valid/ready toggling
    for (int i = 0; i < 4; i++) wsrc[i] = 16'(16'h0B01 + i);
    wb = wlog_addr.size();
    run_cmd(1'b1, 16'h0100, 16'd4, 5, 1'b1, dcyc, dcnt);
    chk("bp_w_nwrites", 64'(wlog_addr.size() - wb), 64'd1);
    chk("bp_w_data", wlog_data[wb], 64'h0B04_0B03_0B02_0B01);
    chk("bp_w_done_cnt", 64'(dcnt), 64'd1);
    run_cmd(1'b0, 16'h0100, 16'd4, 5, 1'b1, dcyc, dcnt);
    chk("bp_r_count", 64'(rd_got.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_rd%0d", i), 64'(rd_got[i]), 64'(16'h0B01 + i));
    chk("bp_r_done_cyc", 64'(dcyc), 64'd16);

    // Reset in the middle of a write chunk
    wb = wlog_addr.size(); wa = wen_any; dt = done_total;
    cmd_write = 1'b1; cmd_addr = 16'h0300; cmd_len = 16'd4; cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 16'h0C01;
    @(posedge clock); #1;
    wr_data = 16'h0C02;
    @(posedge clock); #1;
    wr_valid = 1'b0;
    chk("mid_wr_ready", 64'(wr_ready), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_busy",      64'(busy),      64'd0);
    chk("abort_wr_ready",  64'(wr_ready),  64'd0);
    chk("abort_mem_req",   64'(mem_req),   64'd0);
    chk("abort_mem_wen",   64'(mem_wen),   64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("abort_no_write", 64'(wlog_addr.size() - wb), 64'd0);
    chk("abort_no_wen",   64'(wen_any - wa),          64'd0);
    chk("abort_no_done",  64'(done_total - dt),       64'd0);
    for (int i = 0; i < 4; i++) wsrc[i] = 16'(16'hD001 + i);
    run_cmd(1'b1, 16'h0200, 16'd4, 0, 1'b0, dcyc, dcnt);
    chk("post_rst_nwrites", 64'(wlog_addr.size() - wb), 64'd1);
    chk("post_rst_addr",    64'(wlog_addr[wb]), 64'h0200);
    chk("post_rst_data",    wlog_data[wb],      64'hD004_D003_D002_D001);
    chk("post_rst_done",    64'(dcnt),          64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
